// File: rtl/board_pkg.sv
// Board-wide constants shared by the KEY/SW front-end and the timer datapath:
// clock rate, default debounce/repeat timings and the auto-repeat state encoding.
package board_pkg;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ms_to_cyc(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEBOUNCE_20MS = ms_to_cyc(20);
    localparam int REPEAT_500MS  = ms_to_cyc(500);
    localparam int REPEAT_100MS  = ms_to_cyc(100);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-FF synchroniser, stability counter, debounced level and
// registered rise/fall pulses that trail the level edge by one cycle.
module debounce_cell
    import board_pkg::*;
#(
    parameter logic INIT         = 1'b0,
    parameter int   DEBOUNCE_CYC = DEBOUNCE_20MS
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_next;
    logic             level_d_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The counter only advances while the synchronised input disagrees with the
    // accepted level; any agreement throws the partial count away.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST)
                level_next = sync2_reg;
            else if (cnt_reg != '1)
                cnt_next = cnt_reg + 1'b1;
            else
                cnt_next = cnt_reg;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_reg   <= INIT;
            sync2_reg   <= INIT;
            level_reg   <= INIT;
            level_d_reg <= INIT;
            cnt_reg     <= '0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            sync1_reg   <= raw;
            sync2_reg   <= sync1_reg;
            level_reg   <= level_next;
            level_d_reg <= level_reg;
            cnt_reg     <= cnt_next;
            rise_reg    <= level_reg & ~level_d_reg;
            fall_reg    <= ~level_reg & level_d_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// KEY/SW front-end: debounced levels, press/release/change pulses and a
// per-key auto-repeat engine feeding hold-to-step timer setting.
module input_conditioner
    import board_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int N_SW          = 10,
    parameter int DEBOUNCE_CYC  = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY  = REPEAT_500MS,
    parameter int REPEAT_PERIOD = REPEAT_100MS
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_level,
    output logic [N_SW-1:0]   sw_change
);

    localparam int               RPT_W       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // Key cells run in pin polarity (1 = released), so a raw-level fall is a press.
    logic [N_KEYS-1:0] key_pin_level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_SW-1:0]   sw_rise;
    logic [N_SW-1:0]   sw_fall;

    assign key_level = ~key_pin_level;
    assign sw_change = sw_rise | sw_fall;

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            debounce_cell #(
                .INIT         (1'b0),
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_cell (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .raw      (sw_raw[gi]),
                .level    (sw_level[gi]),
                .rise     (sw_rise[gi]),
                .fall     (sw_fall[gi])
            );
        end

        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            rpt_state_e       state_reg;
            rpt_state_e       state_next;
            logic [RPT_W-1:0] cnt_reg;
            logic [RPT_W-1:0] cnt_next;
            logic             rpt_pulse_reg;
            logic             rpt_pulse_next;
            logic             prev_level_reg;
            logic             press_det;
            logic             abort;

            debounce_cell #(
                .INIT         (1'b1),
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_cell (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .raw      (key_n[gi]),
                .level    (key_pin_level[gi]),
                .rise     (key_release[gi]),
                .fall     (press_pulse[gi])
            );

            // Fires in the same cycle the press pulse register is being loaded,
            // so the DELAY count starts aligned with the press pulse.
            assign press_det = key_level[gi] & ~prev_level_reg;
            assign abort     = ~key_level[gi] | ~repeat_en[gi];

            always_comb begin
                state_next     = state_reg;
                cnt_next       = cnt_reg;
                rpt_pulse_next = 1'b0;
                case (state_reg)
                    IDLE: begin
                        cnt_next = '0;
                        if (press_det && repeat_en[gi])
                            state_next = DELAY;
                    end
                    DELAY: begin
                        if (abort) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == DELAY_LAST) begin
                            rpt_pulse_next = 1'b1;
                            cnt_next       = '0;
                            state_next     = REPEAT;
                        end else begin
                            cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (abort) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == PERIOD_LAST) begin
                            rpt_pulse_next = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    state_reg      <= IDLE;
                    cnt_reg        <= '0;
                    rpt_pulse_reg  <= 1'b0;
                    prev_level_reg <= 1'b0;
                end else begin
                    state_reg      <= state_next;
                    cnt_reg        <= cnt_next;
                    rpt_pulse_reg  <= rpt_pulse_next;
                    prev_level_reg <= key_level[gi];
                end
            end

            assign key_press[gi] = press_pulse[gi] | rpt_pulse_reg;
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Cycle-exact bench for input_conditioner with short debounce/repeat timings;
// pulse expectations go through a cycle-stamped scoreboard.
module tb_input_conditioner;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  key_n    = 4'hF;
    logic [9:0]  sw_raw   = 10'h0;
    logic [3:0]  repeat_en = 4'h0;
    logic [3:0]  key_level;
    logic [3:0]  key_press;
    logic [3:0]  key_release;
    logic [9:0]  sw_level;
    logic [9:0]  sw_change;

    int unsigned cyc = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [9:0]  chg;
    } exp_t;

    exp_t sb[$];

    input_conditioner #(
        .N_KEYS        (4),
        .N_SW          (10),
        .DEBOUNCE_CYC  (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse monitor: every nonzero pulse must match a scoreboard entry stamped with this cycle.
    always @(negedge CLOCK_50) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL sb_missed cyc=%0d required press=%b rel=%b chg=%h never compared", e.cyc, e.press, e.rel, e.chg);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            tests_run++;
            if (key_press !== e.press || key_release !== e.rel || sw_change !== e.chg) begin
                tests_failed++;
                $display("FAIL sb_pulse cyc=%0d press=%b required %b rel=%b required %b chg=%h required %h",
                         cyc, key_press, e.press, key_release, e.rel, sw_change, e.chg);
            end
        end else if ((key_press | key_release) !== 4'h0 || sw_change !== 10'h0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_unexpected cyc=%0d press=%b rel=%b chg=%h required all zero",
                     cyc, key_press, key_release, sw_change);
        end
    end

    task automatic push_exp(input int unsigned c, input logic [3:0] p, input logic [3:0] r, input logic [9:0] ch);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.chg = ch;
        sb.push_back(e);
    endtask

    // Caller is always parked on a falling edge; returns on the falling edge of cycle c.
    task automatic goto_neg(input int unsigned c);
        while (cyc < c) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        int unsigned k;
        goto_neg(cyc + 3);
        tests_run++;
        if ({key_level, key_press, key_release, sw_level, sw_change} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h required 0", {key_level, key_press, key_release, sw_level, sw_change});
        end
        reset = 1'b0;
        k = cyc;
        goto_neg(k + 12);
        tests_run++;
        if (key_level !== 4'h0 || sw_level !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_release_levels key_level=%b sw_level=%h required 0/0", key_level, sw_level);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_sb_drained entries=%0d required 0", sb.size());
        end
    endtask

    task automatic test_clean_press();
        int unsigned k;
        k = cyc;
        key_n[1] = 1'b0;
        push_exp(k + 7, 4'b0010, 4'b0000, 10'h0);
        goto_neg(k + 5);
        tests_run++;
        if (key_level !== 4'b0000) begin
            tests_failed++;
            $display("FAIL press_level_early key_level=%b required 0000", key_level);
        end
        goto_neg(k + 6);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL press_level_accept key_level=%b required 0010", key_level);
        end
        goto_neg(k + 10);
        tests_run++;
        if (key_level !== 4'b0010 || sw_level !== 10'h0) begin
            tests_failed++;
            $display("FAIL press_level_hold key_level=%b sw_level=%h required 0010/000", key_level, sw_level);
        end
        k = cyc;
        key_n[1] = 1'b1;
        push_exp(k + 7, 4'b0000, 4'b0010, 10'h0);
        goto_neg(k + 5);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL release_level_early key_level=%b required 0010", key_level);
        end
        goto_neg(k + 6);
        tests_run++;
        if (key_level !== 4'b0000) begin
            tests_failed++;
            $display("FAIL release_level_accept key_level=%b required 0000", key_level);
        end
        goto_neg(k + 12);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL press_sb_drained entries=%0d required 0", sb.size());
        end
    endtask

    task automatic test_bounce_reject();
        int unsigned k;
        k = cyc;
        for (int i = 0; i < 30; i++) begin
            key_n[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            goto_neg(k + i + 1);
            tests_run++;
            if (key_level[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_level step=%0d key_level[0]=%b required 0", i, key_level[0]);
            end
        end
        key_n[0] = 1'b1;
        goto_neg(cyc + 10);
        tests_run++;
        if (key_level !== 4'h0) begin
            tests_failed++;
            $display("FAIL bounce_settle key_level=%b required 0000", key_level);
        end
    endtask

    task automatic test_auto_repeat();
        int unsigned k;
        int unsigned a;
        repeat_en[1] = 1'b1;
        k = cyc;
        a = k + 6;
        key_n[1] = 1'b0;
        push_exp(a + 1, 4'b0010, 4'b0000, 10'h0);
        for (int j = 0; j < 10; j++)
            push_exp(a + 21 + 5 * j, 4'b0010, 4'b0000, 10'h0);
        push_exp(a + 69, 4'b0000, 4'b0010, 10'h0);
        goto_neg(a + 40);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL repeat_level_hold key_level=%b required 0010", key_level);
        end
        goto_neg(a + 62);
        key_n[1] = 1'b1;
        goto_neg(a + 90);
        tests_run++;
        if (key_level !== 4'b0000 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL repeat_release key_level=%b entries=%0d required 0000/0", key_level, sb.size());
        end
    endtask

    task automatic test_repeat_abort();
        int unsigned k;
        int unsigned a;
        repeat_en[1] = 1'b1;
        k = cyc;
        a = k + 6;
        key_n[1] = 1'b0;
        push_exp(a + 1, 4'b0010, 4'b0000, 10'h0);
        push_exp(a + 21, 4'b0010, 4'b0000, 10'h0);
        goto_neg(a + 25);
        repeat_en[1] = 1'b0;
        goto_neg(a + 27);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_level key_level=%b required 0010", key_level);
        end
        // Re-enabling must not restart repeats: the engine only leaves IDLE on a fresh press.
        repeat_en[1] = 1'b1;
        goto_neg(a + 60);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_idle_level key_level=%b required 0010", key_level);
        end
        key_n[1] = 1'b1;
        push_exp(a + 67, 4'b0000, 4'b0010, 10'h0);
        goto_neg(a + 75);
        repeat_en[1] = 1'b0;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_sb_drained entries=%0d required 0", sb.size());
        end
    endtask

    task automatic test_switch_change();
        int unsigned k;
        k = cyc;
        sw_raw = 10'h081;
        push_exp(k + 7, 4'b0000, 4'b0000, 10'h081);
        goto_neg(k + 5);
        tests_run++;
        if (sw_level !== 10'h000) begin
            tests_failed++;
            $display("FAIL sw_level_early sw_level=%h required 000", sw_level);
        end
        goto_neg(k + 6);
        tests_run++;
        if (sw_level !== 10'h081) begin
            tests_failed++;
            $display("FAIL sw_level_accept sw_level=%h required 081", sw_level);
        end
        goto_neg(k + 12);
        tests_run++;
        if (sw_level !== 10'h081 || key_level !== 4'h0) begin
            tests_failed++;
            $display("FAIL sw_level_hold sw_level=%h key_level=%b required 081/0000", sw_level, key_level);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned k;
        k = cyc;
        sw_raw = 10'h000;
        key_n[3:2] = 2'b00;
        push_exp(k + 7, 4'b1100, 4'b0000, 10'h081);
        goto_neg(k + 6);
        tests_run++;
        if (key_level !== 4'b1100 || sw_level !== 10'h000) begin
            tests_failed++;
            $display("FAIL b2b_levels key_level=%b sw_level=%h required 1100/000", key_level, sw_level);
        end
        goto_neg(k + 10);
        k = cyc;
        key_n[3:2] = 2'b11;
        push_exp(k + 7, 4'b0000, 4'b1100, 10'h0);
        goto_neg(k + 12);
        tests_run++;
        if (key_level !== 4'b0000 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_release key_level=%b entries=%0d required 0000/0", key_level, sb.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        int unsigned k;
        int unsigned a;
        int unsigned r;
        repeat_en[1] = 1'b1;
        k = cyc;
        a = k + 6;
        key_n[1] = 1'b0;
        push_exp(a + 1, 4'b0010, 4'b0000, 10'h0);
        push_exp(a + 21, 4'b0010, 4'b0000, 10'h0);
        push_exp(a + 26, 4'b0010, 4'b0000, 10'h0);
        goto_neg(a + 28);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midreset_pre key_level=%b required 0010", key_level);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({key_level, key_press, key_release, sw_level, sw_change} !== 36'h0) begin
            tests_failed++;
            $display("FAIL midreset_async got %h required 0", {key_level, key_press, key_release, sw_level, sw_change});
        end
        goto_neg(a + 30);
        reset = 1'b0;
        r = cyc;
        push_exp(r + 7, 4'b0010, 4'b0000, 10'h0);
        push_exp(r + 27, 4'b0010, 4'b0000, 10'h0);
        push_exp(r + 32, 4'b0010, 4'b0000, 10'h0);
        push_exp(r + 37, 4'b0010, 4'b0000, 10'h0);
        push_exp(r + 40, 4'b0000, 4'b0010, 10'h0);
        goto_neg(r + 5);
        tests_run++;
        if (key_level !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_relevel_early key_level=%b required 0000", key_level);
        end
        goto_neg(r + 6);
        tests_run++;
        if (key_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midreset_relevel key_level=%b required 0010", key_level);
        end
        goto_neg(r + 33);
        key_n[1] = 1'b1;
        goto_neg(r + 55);
        repeat_en[1] = 1'b0;
        tests_run++;
        if (key_level !== 4'b0000 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL midreset_end key_level=%b entries=%0d required 0000/0", key_level, sb.size());
        end
    endtask

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_auto_repeat();
        test_repeat_abort();
        test_switch_change();
        test_back_to_back();
        test_reset_mid_hold();
        goto_neg(cyc + 3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d required completion", cyc);
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
